result_deskew_collector: RTL and testbench

//  Output-side counterpart of the activation skew buffer. Row r of the

---
 rtl/result_deskew_collector_if.sv | 25 ++
 rtl/result_deskew_collector.sv | 100 ++++++++++
 tb/tb_result_deskew_collector.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_deskew_collector_if.sv
// Handshake/data bundle between the systolic array column outputs, the
// result de-skew collector and the writeback consumer.
interface result_deskew_collector_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8
);
  logic                          capture;
  logic [N-1:0][DATA_W-1:0]      col_val;
  logic                          in_ready;
  logic                          out_valid;
  logic                          out_ready;
  logic [N*N-1:0][DATA_W-1:0]    result;
  logic                          busy;
  logic                          overflow;

  modport master (
    output capture, col_val, out_ready,
    input  in_ready, out_valid, result, busy, overflow
  );

  modport slave (
    input  capture, col_val, out_ready,
    output in_ready, out_valid, result, busy, overflow
  );
endinterface

// File: rtl/result_deskew_collector.sv
// Samples each systolic-array column's staggered stream and rebuilds an
// aligned N x N result tile, handed to writeback with valid/ready.
module result_deskew_collector #(
  parameter int N      = 4,
  parameter int DATA_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  result_deskew_collector_if.slave    bus
);

  localparam int CNT_W = ($clog2(2*N-1) < 1) ? 1 : $clog2(2*N-1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*N-2);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [N*N-1:0][DATA_W-1:0]    result_q, result_d;
  logic                          overflow_q, overflow_d;

  // Next-state, de-skew write selection and overflow detection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    if (bus.capture && (state_q != ST_IDLE)) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.capture) begin
          state_d     = ST_COLLECT;
          cnt_d       = CNT_W'(1);
          result_d[0] = bus.col_val[0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        // Entry (r,c) arrives on column c exactly r+c cycles after capture
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            if (cnt_q == CNT_W'(r + c)) begin
              result_d[r*N+c] = bus.col_val[c];
            end else begin
              result_d[r*N+c] = result_q[r*N+c];
            end
          end
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, tile storage and sticky overflow registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_COLLECT) || (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_result_deskew_collector.sv
// Self-checking bench for result_deskew_collector: directed table, corner
// sequences and randomized traffic against a timestamp-based tile model.
module tb_result_deskew_collector;

  localparam int N = 4;
  localparam int W = 8;

  logic clk;
  logic reset;
  logic cap;
  logic rdy;
  logic [N-1:0][W-1:0] col;

  result_deskew_collector_if #(.N(N), .DATA_W(W)) bus ();

  assign bus.capture   = cap;
  assign bus.col_val   = col;
  assign bus.out_ready = rdy;

  result_deskew_collector #(.N(N), .DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model: every applied column sample is logged per edge; a tile
  // entry (r,c) is simply the column-c sample logged at edge t0+r+c.
  logic [N-1:0][W-1:0]   hist [0:4095];
  int                    e;
  bit                    m_active;
  bit                    m_has;
  bit                    m_ovf;
  int                    m_t0;
  logic [N*N-1:0][W-1:0] m_prev;

  function automatic logic [N*N-1:0][W-1:0] exp_result();
    logic [N*N-1:0][W-1:0] res;
    int r;
    int c;
    int te;
    for (int i = 0; i < N*N; i++) begin
      r  = i / N;
      c  = i % N;
      te = m_t0 + r + c;
      if (m_has && te <= e - 1) res[i] = hist[te][c];
      else                      res[i] = m_prev[i];
    end
    return res;
  endfunction

  function automatic bit exp_valid();
    return m_active && ((e - 1 - m_t0) >= 2*N-2);
  endfunction

  task automatic model_clear();
    m_active = 1'b0;
    m_has    = 1'b0;
    m_ovf    = 1'b0;
    m_t0     = 0;
    m_prev   = '0;
  endtask

  task automatic model_edge();
    hist[e] = col;
    if (!reset) begin
      model_clear();
    end else if (!m_active) begin
      if (cap) begin
        m_prev   = exp_result();
        m_active = 1'b1;
        m_has    = 1'b1;
        m_t0     = e;
      end
    end else begin
      if (cap) m_ovf = 1'b1;
      if ((e - m_t0) >= 2*N-1 && rdy) m_active = 1'b0;
    end
    e++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic check_all(input string nm);
    chk({nm, "_valid"},    128'(bus.out_valid), 128'(exp_valid()));
    chk({nm, "_busy"},     128'(bus.busy),      128'(m_active));
    chk({nm, "_in_ready"}, 128'(bus.in_ready),  128'(!m_active));
    chk({nm, "_overflow"}, 128'(bus.overflow),  128'(m_ovf));
    chk({nm, "_result"},   128'(bus.result),    128'(exp_result()));
  endtask

  // Column samples at offset k for a tile whose entry (r,c) = base+16r+c
  function automatic logic [N-1:0][W-1:0] pat(input int k, input logic [W-1:0] base);
    logic [N-1:0][W-1:0] v;
    for (int c = 0; c < N; c++) begin
      if ((k - c) >= 0 && (k - c) <= N-1) v[c] = base + W'(16*(k-c) + c);
      else                                v[c] = 8'hFF;
    end
    return v;
  endfunction

  function automatic logic [N*N-1:0][W-1:0] tile_exp(input logic [W-1:0] base);
    logic [N*N-1:0][W-1:0] t;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        t[r*N+c] = base + W'(16*r + c);
    return t;
  endfunction

  task automatic do_reset(input int ncyc);
    reset = 1'b0;
    model_clear();
    #1;
    chk("rst_result",   128'(bus.result),    128'(0));
    chk("rst_valid",    128'(bus.out_valid), 128'(0));
    chk("rst_busy",     128'(bus.busy),      128'(0));
    chk("rst_overflow", 128'(bus.overflow),  128'(0));
    for (int i = 0; i < ncyc; i++) begin
      cap = 1'($urandom_range(0, 1));
      col = $urandom;
      step();
      chk("rst_hold_result", 128'(bus.result),    128'(0));
      chk("rst_hold_valid",  128'(bus.out_valid), 128'(0));
    end
    reset = 1'b1;
    cap   = 1'b0;
  endtask

  typedef struct {
    logic                  cap;
    logic                  rdy;
    logic [N-1:0][W-1:0]   col;
    logic                  ev;
    logic                  eb;
    logic                  ei;
    logic                  cr;
    logic [N*N-1:0][W-1:0] er;
  } vec_t;

  vec_t tbl [16];
  logic [N*N-1:0][W-1:0] snap;

  initial begin
    int k;
    logic [W-1:0] base;

    n_chk = 0;
    n_fail = 0;
    e = 0;
    model_clear();

    // Two back-to-back tiles, 8 cycles apart, consumer always ready
    for (int s = 0; s < 16; s++) begin
      k    = s % 8;
      base = (s < 8) ? 8'h01 : 8'h81;
      tbl[s].cap = (k == 0);
      tbl[s].rdy = 1'b1;
      tbl[s].col = (k <= 6) ? pat(k, base) : {N{8'hFF}};
      tbl[s].ev  = (k == 6);
      tbl[s].eb  = (k <= 6);
      tbl[s].ei  = (k == 7);
      tbl[s].cr  = (k >= 6);
      tbl[s].er  = tile_exp(base);
    end

    // Reset held with random activity on the inputs
    reset = 1'b0;
    rdy   = 1'b0;
    cap   = 1'b0;
    col   = '0;
    for (int i = 0; i < 5; i++) begin
      cap = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      col = $urandom;
      step();
      chk("t1_result",   128'(bus.result),    128'(0));
      chk("t1_valid",    128'(bus.out_valid), 128'(0));
      chk("t1_busy",     128'(bus.busy),      128'(0));
      chk("t1_overflow", 128'(bus.overflow),  128'(0));
    end
    reset = 1'b1;
    cap   = 1'b0;
    rdy   = 1'b1;
    #1;
    chk("t1_in_ready", 128'(bus.in_ready), 128'(1));
    step();
    check_all("t1_idle");

    // Table: single tile then back-to-back second tile
    for (int s = 0; s < 16; s++) begin
      cap = tbl[s].cap;
      rdy = tbl[s].rdy;
      col = tbl[s].col;
      step();
      chk("tbl_valid",    128'(bus.out_valid), 128'(tbl[s].ev));
      chk("tbl_busy",     128'(bus.busy),      128'(tbl[s].eb));
      chk("tbl_in_ready", 128'(bus.in_ready),  128'(tbl[s].ei));
      chk("tbl_overflow", 128'(bus.overflow),  128'(0));
      if (tbl[s].cr) chk("tbl_result", 128'(bus.result), 128'(tbl[s].er));
      check_all("tbl_model");
    end

    // Backpressure: tile waits while columns keep toggling
    rdy = 1'b0;
    for (int kk = 0; kk < 7; kk++) begin
      cap = (kk == 0);
      col = pat(kk, 8'h21);
      step();
    end
    chk("bp_valid_rise", 128'(bus.out_valid), 128'(1));
    snap = tile_exp(8'h21);
    chk("bp_result", 128'(bus.result), 128'(snap));
    for (int i = 0; i < 5; i++) begin
      col = $urandom;
      step();
      chk("bp_valid_hold",  128'(bus.out_valid), 128'(1));
      chk("bp_result_hold", 128'(bus.result),    128'(snap));
    end
    rdy = 1'b1;
    step();
    chk("bp_valid_drop", 128'(bus.out_valid), 128'(0));
    chk("bp_in_ready",   128'(bus.in_ready),  128'(1));
    check_all("bp_model");

    // Early second capture at t0+3 is dropped and flags overflow
    for (int kk = 0; kk < 8; kk++) begin
      cap = (kk == 0) || (kk == 3);
      col = pat(kk, 8'h01);
      step();
      if (kk == 2) chk("ovf_before", 128'(bus.overflow), 128'(0));
      if (kk == 3) chk("ovf_set",    128'(bus.overflow), 128'(1));
      if (kk == 6) chk("ovf_tile",   128'(bus.result),   128'(tile_exp(8'h01)));
      check_all("ovf_model");
    end
    chk("ovf_sticky", 128'(bus.overflow), 128'(1));
    do_reset(1);

    // Reset in the middle of collection, then a clean tile
    for (int kk = 0; kk < 4; kk++) begin
      cap = (kk == 0);
      col = pat(kk, 8'h01);
      step();
    end
    do_reset(1);
    chk("mid_in_ready", 128'(bus.in_ready), 128'(1));
    for (int kk = 0; kk < 8; kk++) begin
      cap = (kk == 0);
      col = pat(kk, 8'h41);
      step();
      if (kk == 6) chk("mid_tile", 128'(bus.result), 128'(tile_exp(8'h41)));
      check_all("mid_model");
    end

    // Column 3 outside its window must not land in result[3]
    for (int kk = 0; kk < 12; kk++) begin
      cap = (kk == 0);
      col = pat(kk, 8'h01);
      if (kk == 2 || kk == 10) col[3] = 8'hAA;
      step();
      if (kk == 6)  chk("win_r3_done", 128'(bus.result[3]), 128'(8'h04));
      if (kk == 11) chk("win_r3_late", 128'(bus.result[3]), 128'(8'h04));
      check_all("win_model");
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        cap = ($urandom_range(0, 4) == 0);
        rdy = 1'($urandom_range(0, 1));
        col = $urandom;
        step();
        check_all("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
